// File: rtl/branch_resolve.sv
// Branch/jump resolution for the ID stage: taken decision, target, operand stall, one-cycle redirect + IF/ID flush.
// Define BRANCH_STATS_EN to add saturating stat_total / stat_taken counters.
module branch_resolve #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid,
   input  logic [3:0]       br_op,
   input  logic [WIDTH-1:0] cmp_out,
   input  logic             opnd_ready,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] rs1_val,
   output logic             stall_req,
   output logic             redirect_valid,
   output logic [WIDTH-1:0] redirect_pc,
   output logic             flush_if
`ifdef BRANCH_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_total,
   output logic [CNT_W-1:0] stat_taken
`endif
);

   // state   | meaning
   // S_IDLE  | no control transfer pending; resolve a fresh one with ready operands
   // S_WAIT  | ID frozen on a branch whose operands are still in flight
   // S_REDIR | redirect + flush driven this cycle; ID contents are wrong-path
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_REDIR = 2'd2
   } state_t;

   localparam logic [3:0] OP_BEQ  = 4'b0001;
   localparam logic [3:0] OP_BGEU = 4'b0110;
   localparam logic [3:0] OP_JAL  = 4'b0111;
   localparam logic [3:0] OP_JALR = 4'b1000;

   state_t           r_state;
   state_t           w_next;
   logic             w_stall;
   logic             w_resolve;
   logic             w_valid_op;
   logic             w_cond_op;
   logic             w_taken;
   logic [WIDTH-1:0] w_target;
   logic [WIDTH-1:0] w_jalr_sum;
   logic             r_redirect_valid;
   logic             r_flush_if;
   logic [WIDTH-1:0] r_redirect_pc;
   logic             w_unused;

   assign w_cond_op  = (br_op >= OP_BEQ) && (br_op <= OP_BGEU);
   assign w_valid_op = w_cond_op || (br_op == OP_JAL) || (br_op == OP_JALR);
   assign w_taken    = (br_op == OP_JAL) || (br_op == OP_JALR) || (w_cond_op && cmp_out[0]);

   // Carry out of both adders is dropped on purpose: targets wrap mod 2^WIDTH.
   assign w_jalr_sum = rs1_val + imm;
   assign w_target   = (br_op == OP_JALR) ? {w_jalr_sum[WIDTH-1:1], 1'b0} : (pc + imm);

   assign w_unused = ^cmp_out[WIDTH-1:1];

   always_comb begin
      w_next    = r_state;
      w_stall   = 1'b0;
      w_resolve = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (br_valid && w_valid_op) begin
               if (!opnd_ready) begin
                  w_stall = 1'b1;
                  w_next  = S_WAIT;
               end else begin
                  w_resolve = 1'b1;
                  if (w_taken) w_next = S_REDIR;
               end
            end
         end
         S_WAIT: begin
            // br_valid dropping here is an external flush of the stalled instruction.
            if (!br_valid || !w_valid_op) begin
               w_next = S_IDLE;
            end else if (!opnd_ready) begin
               w_stall = 1'b1;
            end else begin
               w_resolve = 1'b1;
               w_next    = w_taken ? S_REDIR : S_IDLE;
            end
         end
         S_REDIR: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
      if (rst) begin
         w_next    = S_IDLE;
         w_stall   = 1'b0;
         w_resolve = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_redirect_valid <= 1'b0;
         r_flush_if       <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_state          <= w_next;
         r_redirect_valid <= w_resolve && w_taken;
         r_flush_if       <= w_resolve && w_taken;
         if (w_resolve && w_taken) r_redirect_pc <= w_target;
      end
   end

   assign stall_req      = w_stall;
   assign redirect_valid = r_redirect_valid;
   assign flush_if       = r_flush_if;
   assign redirect_pc    = r_redirect_pc;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] r_stat_total;
   logic [CNT_W-1:0] r_stat_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_total <= '0;
         r_stat_taken <= '0;
      end else if (w_resolve) begin
         if (r_stat_total != {CNT_W{1'b1}}) r_stat_total <= r_stat_total + 1'b1;
         if (w_taken && (r_stat_taken != {CNT_W{1'b1}})) r_stat_taken <= r_stat_taken + 1'b1;
      end
   end

   assign stat_total = r_stat_total;
   assign stat_taken = r_stat_taken;
`else
   localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random traffic against a rule-level model.
// Define BRANCH_STATS_EN to also check the counters (16-bit and a 2-bit saturating instance).
module tb_branch_resolve;

   logic        clk;
   logic        rst;
   logic        br_valid;
   logic [3:0]  br_op;
   logic [31:0] cmp_out;
   logic        opnd_ready;
   logic [31:0] pc;
   logic [31:0] imm;
   logic [31:0] rs1_val;
   logic        stall_req;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush_if;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   logic        m_rv;
   logic [31:0] m_pc;
   logic        m_stalled;
   longint      m_tot;
   longint      m_tkn;
   longint      m_tot2;
   longint      m_tkn2;

`ifdef BRANCH_STATS_EN
   logic [15:0] stat_total, stat_taken;
   logic [1:0]  stat_total2, stat_taken2;
   logic        stall_req2, redirect_valid2, flush_if2;
   logic [31:0] redirect_pc2;
`endif

   branch_resolve #(.WIDTH(32), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_op(br_op), .cmp_out(cmp_out),
      .opnd_ready(opnd_ready), .pc(pc), .imm(imm), .rs1_val(rs1_val),
      .stall_req(stall_req), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush_if(flush_if)
`ifdef BRANCH_STATS_EN
      , .stat_total(stat_total), .stat_taken(stat_taken)
`endif
   );

`ifdef BRANCH_STATS_EN
   branch_resolve #(.WIDTH(32), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_op(br_op), .cmp_out(cmp_out),
      .opnd_ready(opnd_ready), .pc(pc), .imm(imm), .rs1_val(rs1_val),
      .stall_req(stall_req2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
      .flush_if(flush_if2), .stat_total(stat_total2), .stat_taken(stat_taken2)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_valid_op(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd8);
   endfunction

   function automatic bit is_taken(input logic [3:0] op, input logic [31:0] c);
      if (op == 4'd7 || op == 4'd8) return 1'b1;
      if (op >= 4'd1 && op <= 4'd6) return c[0];
      return 1'b0;
   endfunction

   function automatic logic [31:0] target_of(input logic [3:0] op, input logic [31:0] p,
                                             input logic [31:0] im, input logic [31:0] r1);
      longint unsigned s;
      if (op == 4'd8) begin
         s = (longint'(r1) + longint'(im)) % 64'h1_0000_0000;
         s = s - (s % 2);
      end else begin
         s = (longint'(p) + longint'(im)) % 64'h1_0000_0000;
      end
      return s[31:0];
   endfunction

   // One clock: check registered outputs, drive inputs, check stall, advance model.
   task automatic cycle(input logic bv, input logic [3:0] op, input logic [31:0] c, input logic rdy,
                        input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                        input logic rs);
      bit e_stall, res;
      @(negedge clk);
      check("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
      check("flush_if", {63'd0, flush_if}, {63'd0, m_rv});
      check("redirect_pc", {32'd0, redirect_pc}, {32'd0, m_pc});
`ifdef BRANCH_STATS_EN
      check("stat_total", {48'd0, stat_total}, m_tot);
      check("stat_taken", {48'd0, stat_taken}, m_tkn);
      check("stat_total_w2", {62'd0, stat_total2}, m_tot2);
      check("stat_taken_w2", {62'd0, stat_taken2}, m_tkn2);
`endif
      br_valid = bv; br_op = op; cmp_out = c; opnd_ready = rdy;
      pc = p; imm = im; rs1_val = r1; rst = rs;
      #1;
      e_stall = !rs && !m_rv && bv && is_valid_op(op) && !rdy;
      check("stall_req", {63'd0, stall_req}, {63'd0, e_stall});
      res = !rs && !m_rv && bv && is_valid_op(op) && rdy;
      if (rs) begin
         m_rv = 0; m_pc = 0; m_tot = 0; m_tkn = 0; m_tot2 = 0; m_tkn2 = 0;
      end else begin
         if (res && is_taken(op, c)) m_pc = target_of(op, p, im, r1);
         if (res) begin
            if (m_tot < 65535) m_tot++;
            if (m_tot2 < 3) m_tot2++;
            if (is_taken(op, c)) begin
               if (m_tkn < 65535) m_tkn++;
               if (m_tkn2 < 3) m_tkn2++;
            end
         end
         m_rv = res && is_taken(op, c);
      end
      m_stalled = e_stall;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 4'd0, 0, 1, 0, 0, 0, 0);
   endtask

   initial begin
      logic [3:0]  r_op;
      logic [31:0] r_pc, r_imm, r_rs1;
      logic        r_bv;

      rst = 1; br_valid = 0; br_op = 0; cmp_out = 0; opnd_ready = 0;
      pc = 0; imm = 0; rs1_val = 0;
      m_rv = 0; m_pc = 0; m_stalled = 0; m_tot = 0; m_tkn = 0; m_tot2 = 0; m_tkn2 = 0;

      // reset state, with a branch presented during reset
      cycle(1, 4'd1, 1, 0, 32'h40, 4, 0, 1);
      check("reset_stall", {63'd0, stall_req}, 64'd0);
      idle(2);

      // 1: BEQ taken
      cycle(1, 4'd1, 32'h1, 1, 32'h100, 32'h20, 0, 0);
      @(posedge clk); #1;
      check("t1_rv", {63'd0, redirect_valid}, 64'd1);
      check("t1_pc", {32'd0, redirect_pc}, 64'h120);
      idle(2);

      // 2: BNE not taken
      cycle(1, 4'd2, 32'h0, 1, 32'h300, 32'h40, 0, 0);
      idle(2);

      // 3: BLT stalled two cycles, negative offset
      cycle(1, 4'd3, 32'h1, 0, 32'h200, 32'hFFFF_FFF0, 0, 0);
      check("t3_stall0", {63'd0, stall_req}, 64'd1);
      cycle(1, 4'd3, 32'h1, 0, 32'h200, 32'hFFFF_FFF0, 0, 0);
      check("t3_stall1", {63'd0, stall_req}, 64'd1);
      cycle(1, 4'd3, 32'h1, 1, 32'h200, 32'hFFFF_FFF0, 0, 0);
      check("t3_stall2", {63'd0, stall_req}, 64'd0);
      @(posedge clk); #1;
      check("t3_pc", {32'd0, redirect_pc}, 64'h1F0);
      idle(1);

      // 4: JALR bit-0 clear, then a wrong-path BEQ during REDIR
      cycle(1, 4'd8, 0, 1, 32'h500, 32'h4, 32'h1003, 0);
      cycle(1, 4'd1, 1, 0, 32'h600, 32'h10, 0, 0);
      check("t4_redir_stall", {63'd0, stall_req}, 64'd0);
      check("t4_pc", {32'd0, redirect_pc}, 64'h1006);
      @(posedge clk); #1;
      check("t4_no_rv", {63'd0, redirect_valid}, 64'd0);
      idle(1);

      // 5: reset while in WAIT, then JAL wrap-around
      cycle(1, 4'd1, 1, 0, 32'h700, 32'h8, 0, 0);
      cycle(1, 4'd1, 1, 0, 32'h700, 32'h8, 0, 1);
      check("t5_rst_stall", {63'd0, stall_req}, 64'd0);
      idle(3);
      cycle(1, 4'd7, 0, 1, 32'hFFFF_FFFC, 32'h8, 0, 0);
      @(posedge clk); #1;
      check("t5_wrap_pc", {32'd0, redirect_pc}, 64'h4);
      idle(1);

      // 6: three taken, two not taken after a fresh reset
      cycle(0, 4'd0, 0, 1, 0, 0, 0, 1);
      cycle(1, 4'd1, 1, 1, 32'h10, 4, 0, 0); idle(1);
      cycle(1, 4'd2, 0, 1, 32'h10, 4, 0, 0);
      cycle(1, 4'd7, 0, 1, 32'h10, 4, 0, 0); idle(1);
      cycle(1, 4'd6, 0, 1, 32'h10, 4, 0, 0);
      cycle(1, 4'd5, 1, 1, 32'h10, 4, 0, 0); idle(1);
`ifdef BRANCH_STATS_EN
      check("t6_total", {48'd0, stat_total}, 64'd5);
      check("t6_taken", {48'd0, stat_taken}, 64'd3);
      check("t6_total_w2", {62'd0, stat_total2}, 64'd3);
`endif

      // random traffic; operands held stable while the model says ID is stalled
      r_op = 0; r_pc = 0; r_imm = 0; r_rs1 = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!m_stalled) begin
            r_op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            r_pc  = $urandom;
            r_imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
            r_rs1 = $urandom;
            r_bv  = ($urandom_range(0, 3) != 0);
         end else begin
            r_bv  = ($urandom_range(0, 7) != 0);
         end
         cycle(r_bv, r_op, $urandom, ($urandom_range(0, 2) != 0), r_pc, r_imm, r_rs1,
               ($urandom_range(0, 99) == 0));
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumes the condition result produced by the comparator in the ID stage, together with the decoded branch/jump info.
- Decides taken/not-taken, computes the target, and issues a registered one-cycle PC redirect plus IF/ID flush to the fetch stage.
- Holds a stall request while branch operands are still in flight (load-use / forwarding not yet available).
- Sits between the comparator/ID decode and the PC register / IF stage.

Parameters:
- WIDTH, 32, datapath width of PC, immediate and operand.
- CNT_W, 16, width of statistic counters (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- br_valid  input  1  ID holds a control-transfer instruction this cycle.
- br_op  input  4  0001 BEQ, 0010 BNE, 0011 BLT, 0100 BGE, 0101 BLTU, 0110 BGEU, 0111 JAL, 1000 JALR; all other codes mean no-op.
- cmp_out  input  WIDTH  comparator result; only bit 0 (condition true) is used.
- opnd_ready  input  1  forwarding logic reports both operands valid.
- pc  input  WIDTH  PC of the ID-stage instruction.
- imm  input  WIDTH  sign-extended offset.
- rs1_val  input  WIDTH  forwarded rs1, used as the JALR base.
- stall_req  output  1  combinational; freezes PC and IF/ID.
- redirect_valid  output  1  registered; load redirect_pc into PC.
- redirect_pc  output  WIDTH  registered target.
- flush_if  output  1  registered; squash the IF/ID contents.

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. On reset, state = IDLE; redirect_valid = 0, flush_if = 0, redirect_pc = 0; stall_req evaluates to 0.
- States: IDLE, WAIT, REDIR.
- Taken decision:
  - JAL and JALR are always taken.
  - BEQ..BGEU are taken when cmp_out[0] = 1.
  - Undefined br_op is never taken and never stalls.
- Targets:
  - Branches and JAL: target = pc + imm.
  - JALR: target = (rs1_val + imm) with bit 0 cleared.
  - Both are mod 2^WIDTH: carry is discarded, wrap-around is legal.
- IDLE:
  - br_valid=1, valid op, opnd_ready=0: stall_req=1, go to WAIT.
  - br_valid=1, opnd_ready=1, taken: latch target into redirect_pc, go to REDIR.
  - br_valid=1, opnd_ready=1, not taken: stay in IDLE, no output change.
  - br_valid=0: stay in IDLE.
- WAIT:
  - stall_req = !opnd_ready.
  - ID is frozen, so pc/imm/br_op are stable.
  - When opnd_ready=1, resolve exactly as IDLE does (to REDIR or IDLE) in the same cycle.
  - If br_valid drops while in WAIT (external flush), return to IDLE with no redirect.
- REDIR:
  - redirect_valid=1 and flush_if=1 for exactly one cycle.
  - br_valid in this cycle belongs to the wrong path: it is ignored and causes no stall.
  - Next state is IDLE unconditionally.
- Latency: decision cycle N gives redirect_valid in cycle N+1. Back-to-back taken branches therefore issue redirects at most every 2 cycles.
- stall_req is never asserted in REDIR, or in any cycle where rst=1.
- Reset in WAIT or REDIR: returns to IDLE next edge; no pending redirect is emitted.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- With the macro defined:
  - Add outputs stat_total and stat_taken (CNT_W each), both reset to 0.
  - stat_total increments on every resolved valid-op branch/jump (the IDLE or WAIT resolution cycle).
  - stat_taken increments on each resolved taken branch/jump.
  - Both counters saturate at all-ones.
- Without the macro: the ports and logic do not exist; all other behaviour is identical.

Test Plan:
1. BEQ taken, pc=0x100, imm=0x20, cmp_out[0]=1, opnd_ready=1 → next cycle redirect_valid=1, redirect_pc=0x120, flush_if=1; both low the cycle after.
2. BNE not taken, cmp_out[0]=0 → redirect_valid, flush_if and stall_req stay 0 throughout.
3. BLT with opnd_ready=0 for 2 cycles, then 1, cmp_out[0]=1, pc=0x200, imm=0xFFFFFFF0 → stall_req=1 for exactly 2 cycles; then redirect_pc=0x1F0.
4. JALR, rs1_val=0x1003, imm=0x4 → redirect_pc=0x1006 (bit 0 cleared). A valid BEQ presented during REDIR is ignored.
5. rst=1 asserted while in WAIT → next cycle stall_req=0 and redirect_valid=0, with no redirect afterward. Wrap case: pc=0xFFFFFFFC, imm=8, JAL → redirect_pc=0x00000004.
6. BRANCH_STATS_EN: 3 taken and 2 not-taken branches → stat_total=5, stat_taken=3. With CNT_W=2, 5 branches → stat_total holds at 3.
